// File: rtl/dct_zigzag_serializer.sv
// dct_zigzag_serializer
//
// Purpose: takes a finished 8x8 coefficient block from the 2-D DCT core.
// It waits for the rising edge of dct_done, then captures the block one
// cycle later, when the DCT output registers are complete. The block goes
// into one of two ping-pong banks. The module then streams the 64
// coefficients one per cycle in JPEG zigzag order. Coefficients pass
// through bit-exact.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   data_in    [u][v] coefficient block (u = row / vertical freq,
//              v = column / horizontal freq), SIZE_COEF bits each, signed
//   dct_done   DCT block-done flag (level; only its rising edge matters)
//   out_ready  downstream accepts a beat this cycle
//   out_valid  out_data / out_index / out_last are valid
//   out_data   current coefficient (0 while out_valid is low)
//   out_index  zigzag position 0..63 of out_data
//   out_last   high on the beat at out_index = 63
//   overrun    sticky: a block was dropped because both banks were full
//   full       both banks hold undrained blocks
//
// Stream handshake: a beat transfers on a clock edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready. While
// out_valid is high and out_ready is low, out_data, out_index and out_last
// hold their values until the beat transfers.
module dct_zigzag_serializer #(
    parameter int SIZE_COEF = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0][7:0][SIZE_COEF-1:0] data_in,
    input  logic                           dct_done,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic signed [SIZE_COEF-1:0]    out_data,
    output logic [5:0]                     out_index,
    output logic                           out_last,
    output logic                           overrun,
    output logic                           full
);

    // Builds the zigzag walk as a constant table. Entry k holds the natural
    // (row*8 + col) address of zigzag position k. The walk moves up-right on
    // even anti-diagonals and down-left on odd ones, and turns at the edges.
    function automatic logic [63:0][5:0] build_zz();
        logic [63:0][5:0] tab;
        int r;
        int c;
        tab = '0;
        r   = 0;
        c   = 0;
        for (int i = 0; i < 64; i++) begin
            tab[i] = 6'(r * 8 + c);
            if (((r + c) & 1) == 0) begin
                if (c == 7)      r = r + 1;
                else if (r == 0) c = c + 1;
                else begin
                    r = r - 1;
                    c = c + 1;
                end
            end else begin
                if (r == 7)      c = c + 1;
                else if (c == 0) r = r + 1;
                else begin
                    r = r + 1;
                    c = c - 1;
                end
            end
        end
        return tab;
    endfunction

    localparam logic [63:0][5:0] ZZ_MAP = build_zz();

    // Each bank stores the block in natural order (row*8 + col).
    logic [63:0][SIZE_COEF-1:0] bank_q [2];

    logic       done_q,    done_d;
    logic       cap_q,     cap_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] fill_q,    fill_d;
    logic [5:0] k_q,       k_d;
    logic       overrun_q, overrun_d;

    logic fire;
    logic last_beat;
    logic cap_accept;
    logic cap_drop;
    logic bank_we;
    logic bank_wsel;

    always_comb begin
        done_d    = dct_done;
        // Rising edge of dct_done. The capture strobe is delayed one cycle
        // because the DCT data settles one cycle after its done flag rises.
        cap_d     = dct_done & ~done_q;

        fire      = out_valid & out_ready;
        last_beat = fire & (k_q == 6'd63);

        // If both banks are full, a capture can still be accepted when the
        // draining bank hands over its final beat on the same edge. The read
        // of that beat and the overwrite of the bank happen on one edge, so
        // the old value is read out before the new one is stored.
        cap_accept = cap_q & ((fill_q != 2'd2) | last_beat);
        cap_drop   = cap_q & ~cap_accept;

        // wr_bank equals rd_bank when fill is 2. So the accepted
        // last-beat capture lands in the bank that is just being freed.
        bank_we   = cap_accept;
        bank_wsel = wr_bank_q;

        wr_bank_d = wr_bank_q ^ cap_accept;
        rd_bank_d = rd_bank_q ^ last_beat;
        k_d       = fire ? k_q + 6'd1 : k_q;

        fill_d = fill_q;
        if (cap_accept && !last_beat) begin
            fill_d = fill_q + 2'd1;
        end else if (!cap_accept && last_beat) begin
            fill_d = fill_q - 2'd1;
        end

        overrun_d = overrun_q | cap_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            cap_q     <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            fill_q    <= 2'd0;
            k_q       <= 6'd0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            cap_q     <= cap_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            fill_q    <= fill_d;
            k_q       <= k_d;
            overrun_q <= overrun_d;
        end
    end

    // Bank contents do not need a reset; they are only read while fill > 0.
    always_ff @(posedge clk) begin
        if (bank_we) begin
            bank_q[bank_wsel] <= data_in;
        end
    end

    always_comb begin
        out_valid = (fill_q != 2'd0);
        out_index = k_q;
        out_last  = out_valid & (k_q == 6'd63);
        out_data  = out_valid ? bank_q[rd_bank_q][ZZ_MAP[k_q]] : '0;
        overrun   = overrun_q;
        full      = (fill_q == 2'd2);
    end

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Bench for dct_zigzag_serializer. The reference model holds the expected
// coefficient stream as one queue. The zigzag order is built by listing the
// anti-diagonals, with the direction alternating on each diagonal.
module tb_dct_zigzag_serializer;
    localparam int W = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0][7:0][W-1:0] data_in = '0;
    logic                   dct_done = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [W-1:0]           out_data;
    logic [5:0]             out_index;
    logic                   out_last;
    logic                   overrun;
    logic                   full;

    dct_zigzag_serializer #(.SIZE_COEF(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .dct_done  (dct_done),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .overrun   (overrun),
        .full      (full)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int zz_ref [64];

    // reference model state
    logic [W-1:0] exp_q [$];
    int           nblk      = 0;
    int           k_m       = 0;
    int           ovr_m     = 0;
    logic         prev_done = 1'b0;
    logic         cap_pend  = 1'b0;

    // observed beat log
    int beat_data [$];
    int beat_idx  [$];
    int beat_last [$];
    int beat_cyc  [$];

    // stall stability tracking
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic [5:0]   prev_index;
    logic         prev_last;

    typedef struct {
        int k;
        int exp_val;
        int exp_last;
    } vec_t;
    vec_t tbl [11];

    int t1_seq [64];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic build_zz_ref();
        int idx;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 1) begin
                for (int r = 0; r < 8; r++) begin
                    if (s - r >= 0 && s - r < 8) begin
                        zz_ref[idx] = r * 8 + (s - r);
                        idx++;
                    end
                end
            end else begin
                for (int r = 7; r >= 0; r--) begin
                    if (s - r >= 0 && s - r < 8) begin
                        zz_ref[idx] = r * 8 + (s - r);
                        idx++;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_block(input int base, input bit rnd);
        for (int i = 0; i < 64; i++) begin
            if (rnd) data_in[i / 8][i % 8] = W'($urandom_range(0, 2047));
            else     data_in[i / 8][i % 8] = W'(base + i);
        end
    endtask

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (nblk > 0);
        chk("valid", int'(out_valid), int'(exp_valid));
        chk("index", int'(out_index), k_m);
        chk("last", int'(out_last), int'(exp_valid && k_m == 63));
        chk("full", int'(full), int'(nblk == 2));
        chk("overrun", int'(overrun), ovr_m);
        if (exp_valid) chk("data", int'(out_data), int'(exp_q[0]));
        else           chk("idle_data", int'(out_data), 0);
        if (stall_prev) begin
            chk("stall_data", int'(out_data), int'(prev_data));
            chk("stall_index", int'(out_index), int'(prev_index));
            chk("stall_last", int'(out_last), int'(prev_last));
        end
    endtask

    // Advances the model across the coming posedge with the inputs just driven.
    task automatic model_step();
        logic fire;
        logic lastb;
        logic acc;
        if (!rst && out_valid && out_ready) begin
            beat_data.push_back(int'(out_data));
            beat_idx.push_back(int'(out_index));
            beat_last.push_back(int'(out_last));
            beat_cyc.push_back(cyc);
        end
        stall_prev = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_index = out_index;
        prev_last  = out_last;
        if (rst) begin
            nblk = 0; k_m = 0; ovr_m = 0;
            exp_q.delete();
            prev_done = 1'b0;
            cap_pend  = 1'b0;
        end else begin
            fire  = (nblk > 0) && out_ready;
            lastb = fire && (k_m == 63);
            acc   = 1'b0;
            if (fire) void'(exp_q.pop_front());
            if (cap_pend) begin
                if (nblk < 2 || lastb) begin
                    acc = 1'b1;
                    for (int k = 0; k < 64; k++) begin
                        int p;
                        p = zz_ref[k];
                        exp_q.push_back(data_in[p / 8][p % 8]);
                    end
                end else begin
                    ovr_m = 1;
                end
            end
            if (fire) k_m = (k_m + 1) % 64;
            nblk = nblk + int'(acc) - int'(lastb);
            cap_pend  = dct_done && !prev_done;
            prev_done = dct_done;
        end
    endtask

    // Called at a negedge: check this cycle, drive its inputs, move to next negedge.
    task automatic cycle(input logic done_i, input logic rdy_i, input logic rst_i);
        cyc++;
        check_outputs();
        rst       = rst_i;
        dct_done  = done_i;
        out_ready = rdy_i;
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0);
    endtask

    task automatic clear_log();
        beat_data.delete(); beat_idx.delete(); beat_last.delete(); beat_cyc.delete();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_last"}, int'(out_last), 0);
        chk({tag, "_index"}, int'(out_index), 0);
        chk({tag, "_data"}, int'(out_data), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_full"}, int'(full), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int n;
        logic sent;
        build_zz_ref();
        tbl[0]  = '{0, 0, 0};   tbl[1]  = '{1, 1, 0};   tbl[2]  = '{2, 8, 0};
        tbl[3]  = '{3, 16, 0};  tbl[4]  = '{4, 9, 0};   tbl[5]  = '{5, 2, 0};
        tbl[6]  = '{6, 3, 0};   tbl[7]  = '{7, 10, 0};  tbl[8]  = '{61, 55, 0};
        tbl[9]  = '{62, 62, 0}; tbl[10] = '{63, 63, 1};

        @(negedge clk);
        chk_reset_state("reset");
        do_reset();

        // Test 1: single block 8u+v, ready high.
        set_block(0, 1'b0);
        clear_log();
        t0 = cyc + 1;
        cycle(1'b1, 1'b1, 1'b0);
        run(75, 1'b1);
        chk("t1_beats", beat_data.size(), 64);
        if (beat_data.size() == 64) begin
            chk("t1_first_cycle", beat_cyc[0], t0 + 2);
            chk("t1_last_cycle", beat_cyc[63], t0 + 65);
            for (int i = 0; i < 11; i++) begin
                chk("t1_tbl_data", beat_data[tbl[i].k], tbl[i].exp_val);
                chk("t1_tbl_last", beat_last[tbl[i].k], tbl[i].exp_last);
                chk("t1_tbl_index", beat_idx[tbl[i].k], tbl[i].k);
            end
            for (int i = 0; i < 64; i++) t1_seq[i] = beat_data[i];
        end
        chk("t1_idle_after", int'(out_valid), 0);

        // Test 2: same block, random ready.
        clear_log();
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        n = 0;
        while (beat_data.size() < 64 && n < 600) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        chk("t2_beats", beat_data.size(), 64);
        if (beat_data.size() == 64) begin
            for (int i = 0; i < 64; i++) chk("t2_seq", beat_data[i], t1_seq[i]);
        end
        run(5, 1'b1);

        // Test 3: +0 and +100 blocks 70 cycles apart, third while second drains.
        clear_log();
        set_block(0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        run(69, 1'b1);
        set_block(100, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        run(29, 1'b1);
        set_block(0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        run(150, 1'b1);
        chk("t3_beats", beat_data.size(), 192);
        if (beat_data.size() == 192) begin
            chk("t3_no_gap", beat_cyc[128], beat_cyc[127] + 1);
            chk("t3_b_first", beat_data[64], 100);
        end
        chk("t3_overrun", int'(overrun), 0);

        // Test 4: three captures with ready low; third dropped.
        clear_log();
        set_block(-300, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        set_block(0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        set_block(500, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        chk("t4_full", int'(full), 1);
        chk("t4_overrun", int'(overrun), 1);
        run(200, 1'b1);
        chk("t4_beats", beat_data.size(), 128);
        do_reset();

        // Test 5: capture aligned with the k=63 transfer while both banks full.
        clear_log();
        set_block(0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        set_block(-100, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        set_block(0, 1'b1);
        sent = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!sent && nblk == 2 && k_m == 62) begin
                cycle(1'b1, 1'b1, 1'b0);
                sent = 1'b1;
            end else begin
                cycle(1'b0, 1'b1, 1'b0);
            end
        end
        chk("t5_aligned", int'(sent), 1);
        chk("t5_beats", beat_data.size(), 192);
        chk("t5_overrun", int'(overrun), 0);

        // Test 6: dct_done held high, then reset mid-block.
        clear_log();
        set_block(0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);
        n = 0;
        while (beat_data.size() < 30 && n < 100) begin
            cycle(1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("t6_reached_30", beat_data.size(), 30);
        chk("t6_single_capture", int'(full), 0);
        cycle(1'b0, 1'b1, 1'b1);
        chk_reset_state("t6_rst");
        clear_log();
        set_block(0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        run(70, 1'b1);
        chk("t6_beats", beat_data.size(), 64);
        if (beat_data.size() > 0) chk("t6_first_index", beat_idx[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dct_zigzag_serializer.md
# dct_zigzag_serializer

Consumer of the 2-D DCT core's parallel 8x8 coefficient output. Captures a completed coefficient block after the DCT asserts its done flag, and re-emits the 64 coefficients one per cycle in JPEG zigzag order on a valid/ready stream toward the quantizer and entropy coder. Two internal block buffers (ping-pong) let the DCT finish the next block while the current one drains.

## Interface
- SIZE_COEF, 11: coefficient width, signed; equals DCT SIZE_OUT-1.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  [7:0][7:0] x SIZE_COEF  DCT coefficient block, signed; data_in[u][v], u = vertical frequency (row), v = horizontal frequency (column).
- dct_done  in  1  DCT block-done flag; may stay high for many cycles.
- out_ready  in  1  downstream can accept a beat this cycle.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_data  out  SIZE_COEF  current coefficient, signed.
- out_index  out  6  zigzag position 0..63 of out_data.
- out_last  out  1  high with the beat at out_index = 63.
- overrun  out  1  sticky; a block was dropped because both buffers were full.
- full  out  1  both buffers hold undrained blocks.

## Operation
- Capture trigger: rising edge of dct_done (high now, low the previous cycle). dct_done held high produces exactly one capture. dct_done high on the first cycle after reset counts as a rising edge.
- Capture timing: the DCT output registers are complete one cycle after dct_done rises. Sample data_in on the clock edge that ends the cycle following the rising-edge cycle. Use a one-cycle delayed capture strobe.
- Buffers: two banks of 64 x SIZE_COEF. State is wr_bank, rd_bank, fill count 0..2, and the 6-bit read index k.
- Capture with fill < 2: write all 64 coefficients into wr_bank, toggle wr_bank, fill++.
- Capture with fill = 2 while the final beat (k = 63, valid & ready) transfers in the same cycle: the capture is accepted. It writes rd_bank after that beat is read out, and fill stays 2.
- Capture with fill = 2 otherwise: drop the block. Set overrun, which clears only on rst. Bank contents are unchanged.
- Read: out_valid = (fill > 0). out_data = bank[rd_bank][zz(k)], where zz is the standard JPEG zigzag map. Examples: k=0->(0,0), 1->(0,1), 2->(1,0), 3->(2,0), 4->(1,1), 5->(0,2), 6->(0,3), 62->(7,6), 63->(7,7).
- Beat handshake: a beat transfers when out_valid & out_ready. Then k++. At k = 63, k wraps to 0, rd_bank toggles and fill--, unless a simultaneous accepted capture holds fill steady.
- Stable output: while out_valid & !out_ready, out_data, out_index and out_last hold steady.
- Idle outputs: out_data = 0 and out_last = 0 when out_valid is low.
- full = (fill == 2).
- Arithmetic: no arithmetic on coefficients; values pass through bit-exact, sign preserved.

## Timing
- Reset state: out_valid=0, out_last=0, out_index=0, out_data=0, overrun=0, full=0, fill=0, both bank pointers 0, edge-detect history=0. Bank contents are don't-care.
- Reset mid-stream: the block in flight and any buffered block are discarded. out_valid is 0 the cycle after rst.
- Latency: dct_done rises in cycle T -> capture at the end of T+1 -> out_valid=1 with index 0 in T+2, when fill was 0.
- Throughput: 1 beat/cycle with out_ready held high. Back-to-back buffered blocks stream with no bubble: index 63 of block A is followed by index 0 of block B in the next cycle.
- Minimum drain time per block: 64 cycles. The DCT block period must be at least 64 cycles, or ready stalls cause drops.

## Test plan
- Single block, data_in[u][v] = 8u+v, out_ready=1, pulse dct_done: 64 beats in cycles T+2..T+65. Sequence is 0,1,8,16,9,2,3,10,... ending 55,62,63. out_last only on beat 63. Then out_valid=0.
- Same block with out_ready toggling pseudo-randomly: identical 64-value sequence. Outputs are held stable on every stalled cycle.
- Two blocks (values +0 and +100) captured 70 cycles apart, ready=1, then a third while the second drains: all 192 beats are in order with no gaps between buffered blocks. overrun stays 0.
- Three captures, ready=0: the first two are accepted, full=1, the third is dropped and overrun=1. Raise ready: exactly 128 beats from blocks 1 and 2.
- With fill=2, align a capture with the k=63 transfer: the capture is accepted, overrun=0, and the new block streams after the next block.
- dct_done held high for 20 cycles: one capture only. Assert rst at beat 30: out_valid=0 next cycle, all outputs are at reset values, and a new dct_done rise streams normally from index 0.
